div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand width; only 32 is supported.
REQ-002 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  execute-stage divide request; held high by the pipeline until ready is seen.
REQ-005 Port: signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 Port: opdata1  input  32  dividend; sampled with start.
REQ-007 Port: opdata2  input  32  divisor; sampled with start.
REQ-008 Port: annul  input  1  pipeline flush of the divide in flight.
REQ-009 Port: divstall  output  1  pipeline stall request, drives the hazard unit.
REQ-010 Port: ready  output  1  result valid.
REQ-011 Port: result  output  64  {remainder[63:32], quotient[31:0]}, i.e. {HI, LO}.

Function
REQ-012 The block SHALL implement four states: IDLE, DIVZERO, BUSY and DONE.
REQ-013 In IDLE with start=1, annul=0 and opdata2=0, the block SHALL go to DIVZERO.
REQ-014 In IDLE with start=1, annul=0 and opdata2!=0, the block SHALL latch the operand magnitudes, clear the 6-bit counter and go to BUSY.
REQ-015 In IDLE with start=0 or annul=1, the block SHALL stay in IDLE.
REQ-016 In DIVZERO, the block SHALL load result = 0 and go to DONE next cycle.
REQ-017 BUSY SHALL perform restoring division, one quotient bit per cycle, MSB first, using a 33-bit partial remainder.
REQ-018 BUSY SHALL last exactly 32 cycles (counter 0..31), then go to DONE.
REQ-019 Latency: start sampled at edge t SHALL give ready=1 in cycle t+33 for a nonzero divisor and in cycle t+2 for a zero divisor.
REQ-020 On leaving BUSY, the block SHALL apply sign correction: quotient negated when the operand signs differ; remainder takes the dividend's sign.
REQ-021 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0 (two's-complement wrap, no trap).
REQ-022 In DONE, ready SHALL be 1 and result SHALL be stable.
REQ-023 In DONE, the block SHALL stay in DONE while start=1 and go to IDLE in the cycle after start=0.
REQ-024 divstall SHALL equal (IDLE & start & ~annul) | DIVZERO | BUSY, and SHALL be 0 in DONE.
REQ-025 annul=1 in DIVZERO or BUSY SHALL force IDLE on the next edge; ready SHALL NOT assert and result SHALL keep its prior value.
REQ-026 annul in DONE SHALL be ignored; DONE exits only via start=0.
REQ-027 ready SHALL be 0 in every state other than DONE.
REQ-028 Outside DONE, result SHALL hold the last DONE value.
REQ-029 Operand changes after the start sample SHALL NOT affect the result.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, counter=0, result=0, ready=0 and divstall=0, including mid-BUSY.
REQ-031 After rst rises, the first start SHALL be accepted at the next edge.

Configuration
REQ-032 Macro DIV_SIGNED_EN, when defined, SHALL enable signed handling: magnitude conversion, sign correction and REQ-021.
REQ-033 Without DIV_SIGNED_EN, signed_div SHALL be ignored and every operation SHALL be unsigned; all timing is unchanged.

Verification
REQ-034 Unsigned 100 / 7 started at t -> ready in cycle t+33, result = {0x00000002, 0x0000000E}, divstall 1 in cycles t..t+32 and 0 at t+33.
REQ-035 Signed -7 / 2 (0xFFFFFFF9 / 2) -> result = {0xFFFFFFFF, 0xFFFFFFFD}; with DIV_SIGNED_EN undefined -> {0x00000001, 0x7FFFFFFC}.
REQ-036 5 / 0 -> DIVZERO, ready in cycle t+2, result = 0, divstall 1 for cycles t and t+1.
REQ-037 annul pulse in the 10th BUSY cycle -> IDLE next edge, ready never asserts, result unchanged; a new start on the following cycle completes correctly.
REQ-038 rst low in the 20th BUSY cycle -> all outputs 0 immediately; signed 0x80000000 / 0xFFFFFFFF after reset -> {0x00000000, 0x80000000}.
REQ-039 start held 5 cycles after ready -> ready and result stable for 6 cycles; IDLE one cycle after start drops.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divider for the execute stage.
// Optional signed DIV support is enabled by defining DIV_SIGNED_EN.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic               divstall,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        DIVZERO,
        BUSY,
        DONE
    } state_t;

    state_t             state_q;
    logic [5:0]         cnt_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH:0]     rem_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     rem_nx;
    logic               qbit;
    logic [WIDTH-1:0]   quo_nx;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH-1:0]   q_fin;
    logic [WIDTH-1:0]   r_fin;
    logic               unused_bits;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff   = trial - {1'b0, dvs_q};
        qbit   = ~diff[WIDTH];
        rem_nx = qbit ? diff : trial;
        quo_nx = {quo_q[WIDTH-2:0], qbit};
    end

`ifdef DIV_SIGNED_EN
    logic neg1;
    logic neg2;
    logic qneg_q;
    logic rneg_q;

    assign neg1  = signed_div & opdata1[WIDTH-1];
    assign neg2  = signed_div & opdata2[WIDTH-1];
    assign mag1  = neg1 ? (0 - opdata1) : opdata1;
    assign mag2  = neg2 ? (0 - opdata2) : opdata2;
    assign q_fin = qneg_q ? (0 - quo_nx) : quo_nx;
    assign r_fin = rneg_q ? (0 - rem_nx[WIDTH-1:0]) : rem_nx[WIDTH-1:0];
    assign unused_bits = rem_q[WIDTH];
`else
    assign mag1  = opdata1;
    assign mag2  = opdata2;
    assign q_fin = quo_nx;
    assign r_fin = rem_nx[WIDTH-1:0];
    assign unused_bits = ^{signed_div, rem_q[WIDTH]};
`endif

    // Stall is held through the whole operation; reset gates it off at once
    assign divstall = rst & ((state_q == IDLE && start && !annul)
                             || state_q == DIVZERO
                             || state_q == BUSY);
    assign ready    = ready_q;
    assign result   = result_q;

    // Control FSM with datapath registers and registered ready/result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !annul) begin
                        if (opdata2 == '0) begin
                            state_q <= DIVZERO;
                        end else begin
                            quo_q   <= mag1;
                            dvs_q   <= mag2;
                            rem_q   <= '0;
                            cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
                            qneg_q  <= neg1 ^ neg2;
                            rneg_q  <= neg1;
`endif
                            state_q <= BUSY;
                        end
                    end
                end
                DIVZERO: begin
                    if (annul) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= '0;
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                BUSY: begin
                    if (annul) begin
                        state_q <= IDLE;
                    end else begin
                        quo_q <= quo_nx;
                        rem_q <= rem_nx;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            result_q <= {r_fin, q_fin};
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        ready_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: table vectors, corner sequences and random ops for div_ctrl.
// Expected values come from plain / and % arithmetic in a local model.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        divstall;
    logic        ready;
    logic [63:0] result;

    int          vecs;
    int          errs;
    logic [63:0] last_res;

    div_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .divstall   (divstall),
        .ready      (ready),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          hold;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: {remainder, quotient} from language-level division
    function automatic logic [63:0] model(input logic sgn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        logic        s_en;
`ifdef DIV_SIGNED_EN
        s_en = sgn;
`else
        s_en = 1'b0 & sgn;
`endif
        if (b == 32'h0) return 64'h0;
        if (s_en) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF)
                return {32'h0, 32'h80000000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        q = a / b;
        r = a % b;
        return {r, q};
    endfunction

    // Issue one divide in the current cycle, follow it to IDLE again
    task automatic do_div(input string nm, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int hold);
        int          lat;
        int          exp_lat;
        int          rdy_cnt;
        logic        stall_ok;
        logic        hold_ok;
        logic        stab_ok;
        logic [63:0] r0;
        exp_lat    = (b == 32'h0) ? 2 : 33;
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        annul      = 1'b0;
        start      = 1'b1;
        #1;
        check({nm, ".stall_t"}, {63'h0, divstall}, 64'h1);
        stall_ok = 1'b1;
        hold_ok  = 1'b1;
        lat      = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = 1'($urandom);
            #1;
            if (ready) break;
            if (divstall !== 1'b1) stall_ok = 1'b0;
            if (result !== last_res) hold_ok = 1'b0;
        end
        check({nm, ".latency"}, 64'(lat), 64'(exp_lat));
        check({nm, ".stall_busy"}, {63'h0, stall_ok}, 64'h1);
        check({nm, ".hold_busy"}, {63'h0, hold_ok}, 64'h1);
        check({nm, ".result"}, result, exp);
        check({nm, ".stall_done"}, {63'h0, divstall}, 64'h0);
        rdy_cnt = 1;
        stab_ok = 1'b1;
        r0      = result;
        repeat (hold) begin
            @(posedge clk);
            #2;
            if (ready) rdy_cnt++;
            if (result !== r0) stab_ok = 1'b0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        if (ready) rdy_cnt++;
        if (result !== r0) stab_ok = 1'b0;
        @(posedge clk);
        #2;
        check({nm, ".ready_cycles"}, 64'(rdy_cnt), 64'(hold + 2));
        check({nm, ".stable"}, {63'h0, stab_ok}, 64'h1);
        check({nm, ".idle_ready"}, {63'h0, ready}, 64'h0);
        check({nm, ".idle_result"}, result, exp);
        last_res = exp;
        #1;
    endtask

    initial begin
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        vecs     = 0;
        errs     = 0;
        last_res = 64'h0;

        tbl[0] = '{1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 4};
        tbl[1] = '{1'b0, 32'd5, 32'd0, 64'h0, 0};
        tbl[2] = '{1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF}, 0};
        tbl[3] = '{1'b0, 32'd7, 32'd100, {32'h7, 32'h0}, 1};
        tbl[4] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'h0, 32'h1}, 0};
`ifdef DIV_SIGNED_EN
        tbl[5] = '{1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0};
        tbl[6] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 0};
        tbl[7] = '{1'b1, 32'd100, 32'hFFFFFFF9, {32'h2, 32'hFFFFFFF2}, 0};
`else
        tbl[5] = '{1'b1, 32'hFFFFFFF9, 32'd2, {32'h1, 32'h7FFFFFFC}, 0};
        tbl[6] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 0};
        tbl[7] = '{1'b1, 32'd100, 32'hFFFFFFF9, {32'h64, 32'h0}, 0};
`endif

        rst        = 1'b0;
        start      = 1'b1;
        signed_div = 1'b0;
        opdata1    = 32'd5;
        opdata2    = 32'd3;
        annul      = 1'b0;
        #3;
        check("reset.ready", {63'h0, ready}, 64'h0);
        check("reset.result", result, 64'h0);
        check("reset.stall", {63'h0, divstall}, 64'h0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;

        for (int i = 0; i < 8; i++)
            do_div($sformatf("tbl%0d", i), tbl[i].sgn, tbl[i].a,
                   tbl[i].b, tbl[i].res, tbl[i].hold);

        // Flush in the 10th BUSY cycle, then restart immediately
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        annul = 1'b0;
        #1;
        check("annul_busy.ready", {63'h0, ready}, 64'h0);
        check("annul_busy.stall", {63'h0, divstall}, 64'h0);
        check("annul_busy.result", result, last_res);
        do_div("after_annul", 1'b0, 32'd1000, 32'd3,
               {32'h1, 32'd333}, 0);

        // Flush while in DIVZERO
        opdata1 = 32'd5;
        opdata2 = 32'd0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        annul = 1'b0;
        #1;
        check("annul_dz.ready", {63'h0, ready}, 64'h0);
        check("annul_dz.result", result, last_res);
        @(posedge clk);
        #2;
        check("annul_dz.ready2", {63'h0, ready}, 64'h0);
        #1;

        // Asynchronous reset in the 20th BUSY cycle
        opdata1 = 32'd12345;
        opdata2 = 32'd11;
        start   = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_busy.ready", {63'h0, ready}, 64'h0);
        check("rst_busy.result", result, 64'h0);
        check("rst_busy.stall", {63'h0, divstall}, 64'h0);
        last_res = 64'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_div("post_rst", 1'b1, 32'h80000000, 32'hFFFFFFFF,
               model(1'b1, 32'h80000000, 32'hFFFFFFFF), 0);

        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
            if ($urandom_range(0, 7) == 0) b = 32'h0;
            do_div($sformatf("rnd%0d", i), s, a, b, model(s, a, b), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
